change_dispenser: RTL and testbench

Sequencer that pays out the change computed by the vending state machine as a series of physical coin requests. The block takes the change amount on a start pulse, decomposes it greedily into 50/20/10/5/1 denominations, and issues one coin request at a time to the coin-ejector interface under a req/ack handshake. It sits between `state_transitions` (which supplies `change_money` and the start pulse) and the ejector/LED drivers. It also reports progress, completion, abort and ejector-timeout fault.

---
 rtl/vend_pkg.sv | 48 ++++
 rtl/change_dispenser_if.sv | 44 ++++
 rtl/change_dispenser_coin_selector.sv | 35 +++
 rtl/change_dispenser.sv | 190 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared vending-machine definitions. The change dispenser, the state
// transition controller and the LED display drivers all use this package.
//   - Coin denomination values (1/5/10/20/50 yuan)
// 	 - One-hot coin_sel encoding (bit0=1, bit1=5, bit2=10, bit3=20, bit4=50)
//   - Dispenser state enum
//   - sel_value(): maps a one-hot selection back to its value in yuan
// ---------------------------------------------------------------------------
package vend_pkg;

  localparam logic [7:0] DENOM_1  = 8'd1;
  localparam logic [7:0] DENOM_5  = 8'd5;
  localparam logic [7:0] DENOM_10 = 8'd10;
  localparam logic [7:0] DENOM_20 = 8'd20;
  localparam logic [7:0] DENOM_50 = 8'd50;

  localparam logic [4:0] SEL_NONE = 5'b00000;
  localparam logic [4:0] SEL_1    = 5'b00001;
  localparam logic [4:0] SEL_5    = 5'b00010;
  localparam logic [4:0] SEL_10   = 5'b00100;
  localparam logic [4:0] SEL_20   = 5'b01000;
  localparam logic [4:0] SEL_50   = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_REQ    = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Value in yuan of a one-hot coin selection; anything not one-hot is 0.
  function automatic logic [7:0] sel_value(input logic [4:0] sel);
    logic [7:0] v;
    case (sel)
      SEL_1:   v = DENOM_1;
      SEL_5:   v = DENOM_5;
      SEL_10:  v = DENOM_10;
      SEL_20:  v = DENOM_20;
      SEL_50:  v = DENOM_50;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// ---------------------------------------------------------------------------
// change_dispenser_if
// Bundles the dispenser's control and ejector signals.
//   master (controller/ejector side): drives start, change_money, abort,
//                                     coin_ack; observes the status outputs
//   slave  (change_dispenser):        the reverse
// Signals: start, change_money[7:0], abort, coin_ack (to dispenser);
//          coin_req, coin_sel[4:0], remaining[7:0], busy, done, fault
//          (from dispenser).
// Macro CHANGE_TALLY_EN adds coin_tally[14:0] (five 3-bit coin counts).
// ---------------------------------------------------------------------------
interface change_dispenser_if;
  logic       start;
  logic [7:0] change_money;
  logic       abort;
  logic       coin_ack;
  logic       coin_req;
  logic [4:0] coin_sel;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       fault;
`ifdef CHANGE_TALLY_EN
  logic [14:0] coin_tally;

  modport master (
    output start, change_money, abort, coin_ack,
    input  coin_req, coin_sel, remaining, busy, done, fault, coin_tally
  );
  modport slave (
    input  start, change_money, abort, coin_ack,
    output coin_req, coin_sel, remaining, busy, done, fault, coin_tally
  );
`else
  modport master (
    output start, change_money, abort, coin_ack,
    input  coin_req, coin_sel, remaining, busy, done, fault
  );
  modport slave (
    input  start, change_money, abort, coin_ack,
    output coin_req, coin_sel, remaining, busy, done, fault
  );
`endif
endinterface

// File: rtl/change_dispenser_coin_selector.sv
// ---------------------------------------------------------------------------
// coin_selector
// Combinational greedy pick: the largest coin not exceeding the amount.
//   amount_i [7:0] : amount still to pay
//   sel_o    [4:0] : one-hot denomination (SEL_NONE when amount is 0)
//   value_o  [7:0] : value of the selected coin in yuan
// ---------------------------------------------------------------------------
module coin_selector
  import vend_pkg::*;
(
  input  logic [7:0] amount_i,
  output logic [4:0] sel_o,
  output logic [7:0] value_o
);

  // Priority compare from the largest denomination downward.
  always_comb begin
    sel_o = SEL_NONE;
    if (amount_i >= DENOM_50) begin
      sel_o = SEL_50;
    end else if (amount_i >= DENOM_20) begin
      sel_o = SEL_20;
    end else if (amount_i >= DENOM_10) begin
      sel_o = SEL_10;
    end else if (amount_i >= DENOM_5) begin
      sel_o = SEL_5;
    end else if (amount_i >= DENOM_1) begin
      sel_o = SEL_1;
    end else begin
      sel_o = SEL_NONE;
    end
    value_o = sel_value(sel_o);
  end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Pays out a change amount as a sequence of single-coin requests to the
// ejector. Coins are chosen greedily (50/20/10/5/1), one request is
// outstanding at a time, and a fixed idle gap follows every acknowledged
// coin.
//   sys_clk, sys_rst : clock; synchronous active-high reset
//   bus (slave)      : start/change_money/abort/coin_ack in;
//                      coin_req/coin_sel/remaining/busy/done/fault out
// Parameters: GAP_CYCLES (1..255) idle cycles after each ack,
//             ACK_TIMEOUT cycles a request may wait before faulting.
// Macro CHANGE_TALLY_EN adds bus.coin_tally, the per-denomination counts
// of acknowledged coins for the current payout.
// All outputs are registered.
// ---------------------------------------------------------------------------
module change_dispenser
  import vend_pkg::*;
#(
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 1000
) (
  input logic sys_clk,
  input logic sys_rst,
  change_dispenser_if.slave bus
);

  localparam int              TO_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [4:0]      sel_q, sel_d;
  logic [7:0]      denom_q, denom_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            fault_q, fault_d;
  logic            coin_req_q, coin_req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [4:0]      pick_sel_s;
  logic [7:0]      pick_val_s;
  logic            start_accept_s;

  coin_selector u_coin_selector (
    .amount_i (remaining_q),
    .sel_o    (pick_sel_s),
    .value_o  (pick_val_s)
  );

  // start only counts in the resting states; it is ignored while busy.
  assign start_accept_s = bus.start &&
                          ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAULT));

  // Next-state and datapath updates; outputs are derived from the next state.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sel_d       = sel_q;
    denom_d     = denom_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    fault_d     = fault_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start_accept_s) begin
          remaining_d = bus.change_money;
          fault_d     = 1'b0;
          state_d     = (bus.change_money == 8'd0) ? ST_DONE : ST_SELECT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_SELECT: begin
        sel_d    = pick_sel_s;
        denom_d  = pick_val_s;
        to_cnt_d = '0;
        state_d  = bus.abort ? ST_IDLE : ST_REQ;
      end
      ST_REQ: begin
        if (bus.coin_ack) begin
          // The ack is honoured even when abort arrives in the same cycle.
          remaining_d = remaining_q - denom_q;
          gap_cnt_d   = 8'd0;
          if (bus.abort) begin
            state_d = ST_IDLE;
          end else if (remaining_d == 8'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
          end
        end else if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_SELECT;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    coin_req_d = (state_d == ST_REQ);
    busy_d     = (state_d == ST_SELECT) || (state_d == ST_REQ) || (state_d == ST_GAP);
    done_d     = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      sel_q       <= SEL_NONE;
      denom_q     <= 8'd0;
      gap_cnt_q   <= 8'd0;
      to_cnt_q    <= '0;
      fault_q     <= 1'b0;
      coin_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      denom_q     <= denom_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
      fault_q     <= fault_d;
      coin_req_q  <= coin_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.coin_req  = coin_req_q;
  assign bus.coin_sel  = sel_q;
  assign bus.remaining = remaining_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;

`ifdef CHANGE_TALLY_EN
  logic [14:0] tally_q, tally_d;

  // Per-denomination counts: cleared on an accepted start, bumped on each ack.
  always_comb begin
    tally_d = tally_q;
    if (start_accept_s) begin
      tally_d = '0;
    end else if ((state_q == ST_REQ) && bus.coin_ack) begin
      for (int i = 0; i < 5; i++) begin
        if (sel_q[i]) begin
          tally_d[3*i +: 3] = tally_q[3*i +: 3] + 3'd1;
        end else begin
          tally_d[3*i +: 3] = tally_q[3*i +: 3];
        end
      end
    end else begin
      tally_d = tally_q;
    end
  end

  // Tally register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tally_q <= 15'd0;
    end else begin
      tally_q <= tally_d;
    end
  end

  assign bus.coin_tally = tally_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
// Self-checking bench for change_dispenser. Expected coin sequences come
// from a greedy decomposition of the amount done with plain arithmetic;
// expected timing comes from the documented cycle relationships.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int GAP = 2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   den_val [5] = '{1, 5, 10, 20, 50};

  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Greedy decomposition of amt into denomination indices, largest first.
  task automatic greedy(input int amt, output int coins [$]);
    int rem;
    coins = {};
    rem = amt;
    while (rem > 0) begin
      for (int i = 4; i >= 0; i--) begin
        if (den_val[i] <= rem) begin
          coins.push_back(i);
          rem -= den_val[i];
          break;
        end
      end
    end
  endtask

  // Full payout; abort_at >= 0 aborts (without ack) while that coin is requested.
  task automatic do_payout(input int amount, input int abort_at);
    int          coins [$];
    int          rem;
    int          waited;
    int          exp_wait;
    int          dly;
    int          cnt [5];
    logic [4:0]  exp_sel;
    logic [14:0] exp_tally;
    greedy(amount, coins);
    rem = amount;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    bus.start = 1'b1;
    bus.change_money = amount[7:0];
    tick();
    bus.start = 1'b0;
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL start_fault_clr: got %b want 0", bus.fault); end
    checks++; if (bus.remaining !== amount[7:0]) begin errors++; $display("FAIL start_remaining: got %0d want %0d", bus.remaining, amount); end
    checks++; if (bus.coin_req !== 1'b0) begin errors++; $display("FAIL start_req_low: got %b want 0", bus.coin_req); end
    if (amount == 0) begin
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", bus.busy); end
    end else begin
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL start_busy: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done); end
    end
    for (int k = 0; k < coins.size(); k++) begin
      exp_wait = (k == 0) ? 1 : GAP + 1;
      waited = 0;
      while (bus.coin_req !== 1'b1 && waited < 50) begin
        tick();
        waited++;
      end
      checks++; if (waited != exp_wait) begin errors++; $display("FAIL req_latency: amount %0d coin %0d got %0d cycles want %0d", amount, k, waited, exp_wait); return; end
      exp_sel = 5'd1 << coins[k];
      checks++; if (bus.coin_sel !== exp_sel) begin errors++; $display("FAIL coin_sel: amount %0d coin %0d got %b want %b", amount, k, bus.coin_sel, exp_sel); end
      if (k == abort_at) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++; if (bus.coin_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_idle: got req=%b busy=%b done=%b want 0/0/0", bus.coin_req, bus.busy, bus.done); end
        checks++; if (bus.remaining !== rem[7:0]) begin errors++; $display("FAIL abort_remaining: got %0d want %0d", bus.remaining, rem); end
        return;
      end
      dly = $urandom_range(0, 3);
      repeat (dly) begin
        tick();
        checks++; if (bus.coin_req !== 1'b1 || bus.coin_sel !== exp_sel) begin errors++; $display("FAIL req_hold: got req=%b sel=%b want 1/%b", bus.coin_req, bus.coin_sel, exp_sel); end
      end
      bus.coin_ack = 1'b1;
      tick();
      bus.coin_ack = 1'b0;
      rem -= den_val[coins[k]];
      cnt[coins[k]]++;
      checks++; if (bus.coin_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", bus.coin_req); end
      checks++; if (bus.remaining !== rem[7:0]) begin errors++; $display("FAIL remaining: amount %0d coin %0d got %0d want %0d", amount, k, bus.remaining, rem); end
      if (k == coins.size() - 1) begin
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL last_done: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
      end else begin
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_done: got done=%b busy=%b want 0/1", bus.done, bus.busy); end
      end
    end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.coin_req !== 1'b0) begin errors++; $display("FAIL after_done: got done=%b busy=%b req=%b want 0/0/0", bus.done, bus.busy, bus.coin_req); end
    exp_tally = '0;
    for (int i = 0; i < 5; i++) exp_tally[3*i +: 3] = cnt[i][2:0];
`ifdef CHANGE_TALLY_EN
    checks++; if (bus.coin_tally !== exp_tally) begin errors++; $display("FAIL tally: amount %0d got %h want %h", amount, bus.coin_tally, exp_tally); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.change_money = 8'd0;
    bus.abort = 1'b0;
    bus.coin_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if ({bus.coin_req, bus.coin_sel, bus.remaining, bus.busy, bus.done, bus.fault} !== 17'd0) begin errors++; $display("FAIL reset_outputs: got req=%b sel=%b rem=%0d busy=%b done=%b fault=%b want all 0", bus.coin_req, bus.coin_sel, bus.remaining, bus.busy, bus.done, bus.fault); end
`ifdef CHANGE_TALLY_EN
    checks++; if (bus.coin_tally !== 15'd0) begin errors++; $display("FAIL reset_tally: got %h want 0", bus.coin_tally); end
`endif
  endtask

  task automatic test_directed();
    do_payout(87, -1);
    do_payout(0, -1);
    do_payout(255, -1);
  endtask

  task automatic test_timeout();
    int n;
    bus.start = 1'b1;
    bus.change_money = 8'd30;
    tick();
    bus.start = 1'b0;
    tick();
    n = 0;
    while (bus.coin_req === 1'b1 && n < 100) begin
      checks++; if (bus.done !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL timeout_wait: got done=%b fault=%b want 0/0", bus.done, bus.fault); end
      n++;
      tick();
    end
    checks++; if (n != TMO) begin errors++; $display("FAIL timeout_len: got %0d req cycles want %0d", n, TMO); end
    checks++; if (bus.fault !== 1'b1 || bus.remaining !== 8'd30 || bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_state: got fault=%b rem=%0d busy=%b want 1/30/0", bus.fault, bus.remaining, bus.busy); end
    repeat (3) tick();
    checks++; if (bus.fault !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL fault_sticky: got fault=%b done=%b want 1/0", bus.fault, bus.done); end
    do_payout(10, -1);
  endtask

  task automatic test_abort();
    bus.start = 1'b1;
    bus.change_money = 8'd26;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.coin_req !== 1'b1 || bus.coin_sel !== 5'b01000) begin errors++; $display("FAIL abort_first_req: got req=%b sel=%b want 1/01000", bus.coin_req, bus.coin_sel); end
    bus.abort = 1'b1;
    bus.coin_ack = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.coin_ack = 1'b0;
    checks++; if (bus.remaining !== 8'd6 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.coin_req !== 1'b0) begin errors++; $display("FAIL abort_ack: got rem=%0d busy=%b done=%b req=%b want 6/0/0/0", bus.remaining, bus.busy, bus.done, bus.coin_req); end
    tick();
    checks++; if (bus.remaining !== 8'd6 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_settle: got rem=%0d done=%b busy=%b want 6/0/0", bus.remaining, bus.done, bus.busy); end
    // start while busy must be ignored
    bus.start = 1'b1;
    bus.change_money = 8'd40;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.change_money = 8'd99;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.remaining !== 8'd40 || bus.coin_req !== 1'b1 || bus.coin_sel !== 5'b01000) begin errors++; $display("FAIL busy_start_ignored: got rem=%0d req=%b sel=%b want 40/1/01000", bus.remaining, bus.coin_req, bus.coin_sel); end
    bus.abort = 1'b1;
    tick();
    checks++; if (bus.remaining !== 8'd40 || bus.busy !== 1'b0 || bus.coin_req !== 1'b0) begin errors++; $display("FAIL abort_req: got rem=%0d busy=%b req=%b want 40/0/0", bus.remaining, bus.busy, bus.coin_req); end
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.remaining !== 8'd40 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_idle_noeffect: got rem=%0d busy=%b done=%b want 40/0/0", bus.remaining, bus.busy, bus.done); end
  endtask

  task automatic test_reset_midpayout();
    bus.start = 1'b1;
    bus.change_money = 8'd50;
    tick();
    bus.start = 1'b0;
    tick();
    checks++; if (bus.coin_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", bus.coin_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.coin_req, bus.coin_sel, bus.remaining, bus.busy, bus.done, bus.fault} !== 17'd0) begin errors++; $display("FAIL rst_mid_outputs: got req=%b sel=%b rem=%0d busy=%b done=%b fault=%b want all 0", bus.coin_req, bus.coin_sel, bus.remaining, bus.busy, bus.done, bus.fault); end
    do_payout(5, -1);
  endtask

  task automatic test_random();
    int amt;
    int ab;
    for (int it = 0; it < 20; it++) begin
      amt = $urandom_range(0, 255);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      do_payout(amt, ab);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_abort();
    test_reset_midpayout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
